// File: rtl/onehot_stream_encoder_if.sv
// Handshake bundle for onehot_stream_encoder: the vector input port and the
// serial index output port. The slave modport is the encoder's view and the
// master modport is the view of the logic around it.
interface onehot_stream_encoder_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_index;
    logic         out_last;
    logic         out_none;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_index, out_last, out_none
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_index, out_last, out_none
    );
endinterface

// File: rtl/onehot_stream_encoder.sv
// onehot_stream_encoder: accepts an N-bit request vector and replays it as a
// stream of binary indices, one per set bit, with a last flag on the final
// beat. An all-zero vector produces a single beat (index 0, none=1).
// Optional build macro ENC_MSB_FIRST_EN: scan highest set bit first instead
// of lowest set bit first.
module onehot_stream_encoder #(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    onehot_stream_encoder_if.slave    bus
);
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         zero_q, zero_d;

    logic [W-1:0] scan_idx;
    logic         at_most_one;

    logic         in_ready_c;
    logic         out_valid_c;
    logic [W-1:0] out_index_c;
    logic         out_last_c;
    logic         out_none_c;

    // Pick the next bit to report from the pending set (last match wins).
    always_comb begin
        scan_idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) scan_idx = W'(i);
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) scan_idx = W'(i);
        end
`endif
    end

    // Clearing the lowest set bit leaves zero iff at most one bit was set.
    assign at_most_one = ((pending_q & (pending_q - N'(1))) == '0);

    // Next-state and output decode; outputs depend only on registered state.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_d      = zero_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_index_c = '0;
        out_last_c  = 1'b0;
        out_none_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    pending_d = bus.in_vec;
                    zero_d    = (bus.in_vec == '0);
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                out_valid_c = 1'b1;
                out_index_c = scan_idx;
                out_last_c  = at_most_one;
                out_none_c  = zero_q;
                if (bus.out_ready) begin
                    if (at_most_one) begin
                        pending_d = '0;
                        state_d   = IDLE;
                    end else begin
                        pending_d = pending_q & ~(N'(1) << scan_idx);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pending set and zero flag registers; reset discards any work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_index = out_index_c;
    assign bus.out_last  = out_last_c;
    assign bus.out_none  = out_none_c;
endmodule

// File: tb/tb_onehot_stream_encoder.sv
// Self-checking bench for onehot_stream_encoder (N=4). A queue-based model
// turns each accepted vector into its list of expected beats; a compare
// process checks the DUT against the model on every falling edge, and
// directed literal checks pin the model on the listed scenarios.
module tb_onehot_stream_encoder;
    localparam int N = 4;
`ifdef ENC_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    onehot_stream_encoder_if #(.N(N)) bus ();

    onehot_stream_encoder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int idx;
        bit last;
        bit none;
    } beat_t;

    typedef struct {
        int idx;
        bit last;
        bit none;
        int cyc;
    } log_t;

    beat_t exp_q[$];
    log_t  log_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    acc_cyc = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model: on accept, list the set bits in scan order; pop one per handshake.
    initial begin
        beat_t b;
        beat_t popped;
        int    cnt;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    log_q.push_back('{int'(bus.out_index), bus.out_last, bus.out_none, cyc});
                    $display("beat  cyc=%0d idx=%0d last=%0b none=%0b", cyc,
                             bus.out_index, bus.out_last, bus.out_none);
                end
                if (exp_q.size() > 0) begin
                    if (bus.out_ready) popped = exp_q.pop_front();
                end else if (bus.in_valid) begin
                    cnt = 0;
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = MSB ? (N - 1 - k) : k;
                        if (bus.in_vec[i]) begin
                            b.idx = i; b.last = 1'b0; b.none = 1'b0;
                            exp_q.push_back(b);
                            cnt++;
                        end
                    end
                    if (cnt == 0) begin
                        b.idx = 0; b.last = 1'b1; b.none = 1'b1;
                        exp_q.push_back(b);
                    end else begin
                        exp_q[exp_q.size() - 1].last = 1'b1;
                    end
                    acc_cyc = cyc;
                    $display("accept cyc=%0d vec=%b beats=%0d", cyc, bus.in_vec, exp_q.size());
                end
                cyc++;
            end
        end
    end

    // Compare DUT against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", int'(bus.out_valid), int'(exp_q.size() > 0));
                chk("in_ready", int'(bus.in_ready), int'(exp_q.size() == 0));
                if (exp_q.size() > 0) begin
                    chk("out_index", int'(bus.out_index), exp_q[0].idx);
                    chk("out_last", int'(bus.out_last), int'(exp_q[0].last));
                    chk("out_none", int'(bus.out_none), int'(exp_q[0].none));
                end
            end
        end
    end

    task automatic send(input logic [N-1:0] v);
        int n;
        n = 0;
        @(negedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_vec   = ~v;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((bus.out_valid || !bus.in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b1;

        // Reset values while rst_n is held low.
        #2;
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst in_ready", int'(bus.in_ready), 1);
        chk("rst out_index", int'(bus.out_index), 0);
        chk("rst out_last", int'(bus.out_last), 0);
        chk("rst out_none", int'(bus.out_none), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // 1010 with out_ready=1.
        log_q.delete();
        send(4'b1010);
        wait_idle();
        chk("t1 beats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t1 idx0", log_q[0].idx, MSB ? 3 : 1);
            chk("t1 last0", int'(log_q[0].last), 0);
            chk("t1 idx1", log_q[1].idx, MSB ? 1 : 3);
            chk("t1 last1", int'(log_q[1].last), 1);
            chk("t1 none", int'(log_q[1].none), 0);
            chk("t1 lat0", log_q[0].cyc - acc_cyc, 1);
            chk("t1 lat1", log_q[1].cyc - acc_cyc, 2);
        end

        // All-zero vector.
        log_q.delete();
        send(4'b0000);
        wait_idle();
        chk("t2 beats", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("t2 idx", log_q[0].idx, 0);
            chk("t2 last", int'(log_q[0].last), 1);
            chk("t2 none", int'(log_q[0].none), 1);
            chk("t2 lat", log_q[0].cyc - acc_cyc, 1);
        end

        // Stall with in_valid held high and in_vec changing.
        log_q.delete();
        bus.out_ready = 1'b0;
        @(negedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_vec   = 4'b1000;
        @(posedge clk); #1;
        bus.in_vec = 4'b0111;
        repeat (5) begin
            @(negedge clk);
            chk("t3 valid", int'(bus.out_valid), 1);
            chk("t3 idx", int'(bus.out_index), 3);
            chk("t3 last", int'(bus.out_last), 1);
            chk("t3 in_ready", int'(bus.in_ready), 0);
        end
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();
        chk("t3 beats", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("t3 log idx", log_q[0].idx, 3);
            chk("t3 log none", int'(log_q[0].none), 0);
        end

        // All ones, back-to-back beats.
        log_q.delete();
        send(4'b1111);
        wait_idle();
        chk("t4 beats", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t4 idx", log_q[k].idx, MSB ? 3 - k : k);
                chk("t4 last", int'(log_q[k].last), int'(k == 3));
                chk("t4 cyc", log_q[k].cyc - acc_cyc, k + 1);
            end
        end

        // Reset in the middle of a transaction.
        log_q.delete();
        bus.out_ready = 1'b0;
        send(4'b0110);
        @(negedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("t5 first beats", log_q.size(), 1);
        if (log_q.size() == 1) chk("t5 first idx", log_q[0].idx, MSB ? 2 : 1);
        @(negedge clk); #1;
        chk("t5 pre valid", int'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t5 rst valid", int'(bus.out_valid), 0);
        chk("t5 rst in_ready", int'(bus.in_ready), 1);
        chk("t5 rst idx", int'(bus.out_index), 0);
        chk("t5 rst last", int'(bus.out_last), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        log_q.delete();
        send(4'b0001);
        wait_idle();
        chk("t5 beats", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("t5 idx", log_q[0].idx, 0);
            chk("t5 last", int'(log_q[0].last), 1);
            chk("t5 none", int'(log_q[0].none), 0);
        end

        // A few more vectors, checked by the model.
        begin
            logic [N-1:0] vecs [4];
            vecs[0] = 4'b0011; vecs[1] = 4'b1100; vecs[2] = 4'b0100; vecs[3] = 4'b1001;
            for (int k = 0; k < 4; k++) begin
                send(vecs[k]);
                wait_idle();
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
